// File: rtl/montgomery_mult_pkg.sv
// Shared definitions for the bit-serial Montgomery multiplier: default width,
// FSM state encoding, adder sizing and the per-bit step decision.
package montgomery_mult_pkg;

    localparam int N_DEFAULT     = 512;
    localparam int ADD_W_DEFAULT = N_DEFAULT + 2;
    localparam int ADD_CHUNK     = 128;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD   = 4'd1,
        ADD_B  = 4'd2,
        WAIT_B = 4'd3,
        ADD_M  = 4'd4,
        WAIT_M = 4'd5,
        SHIFT  = 4'd6,
        SUB    = 4'd7,
        WAIT_S = 4'd8,
        DONE   = 4'd9
    } mont_state_e;

    function automatic int add_width(input int n);
        return n + 2;
    endfunction

    // Step for one multiplier bit: add B if A[i] is set, else fix parity with M, else just shift.
    function automatic mont_state_e next_step(input logic a_bit, input logic c_bit);
        mont_state_e s;
        if (a_bit) begin
            s = ADD_B;
        end else if (c_bit) begin
            s = ADD_M;
        end else begin
            s = SHIFT;
        end
        return s;
    endfunction

endpackage

// File: rtl/montgomery_mult_adder.sv
// Multi-cycle W-bit adder/subtractor: processes ADD_CHUNK bits per cycle,
// done stays high from completion until the next start. Synchronous active-low reset.
module montgomery_mult_adder
    import montgomery_mult_pkg::*;
#(
    parameter int W     = ADD_W_DEFAULT,
    parameter int CHUNK = ADD_CHUNK
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         subtract,
    input  logic         shift,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         done
);
    localparam int NCH = W / CHUNK + 1;
    localparam int PW  = NCH * CHUNK;
    localparam int CW  = $clog2(NCH + 1);

    logic [PW-1:0]  a_r;
    logic [PW-1:0]  b_r;
    logic [PW-1:0]  sum_r;
    logic           carry_r;
    logic [CW-1:0]  cnt_r;
    logic           done_r;
    logic [CHUNK:0] part_s;
    logic [PW-1:0]  a_ext_s;
    logic [PW-1:0]  b_ext_s;

    // One chunk of the ripple sum plus zero-padded operand images.
    always_comb begin
        part_s  = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_r};
        a_ext_s = {{(PW-W){1'b0}}, in_a};
        if (subtract) begin
            b_ext_s = {{(PW-W){1'b0}}, ~in_b};
        end else begin
            b_ext_s = {{(PW-W){1'b0}}, in_b};
        end
    end

    // Operand shift registers; the sum fills from the top so it lands aligned after NCH chunks.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_r     <= {PW{1'b0}};
            b_r     <= {PW{1'b0}};
            sum_r   <= {PW{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            done_r  <= 1'b0;
        end else if (start) begin
            if (shift) begin
                sum_r  <= {{(PW-W+1){1'b0}}, in_a[W-1:1]};
                cnt_r  <= {CW{1'b0}};
                done_r <= 1'b1;
            end else begin
                a_r     <= a_ext_s;
                b_r     <= b_ext_s;
                carry_r <= subtract;
                cnt_r   <= CW'(NCH);
                done_r  <= 1'b0;
            end
        end else if (cnt_r != {CW{1'b0}}) begin
            a_r     <= a_r >> CHUNK;
            b_r     <= b_r >> CHUNK;
            sum_r   <= {part_s[CHUNK-1:0], sum_r[PW-1:CHUNK]};
            carry_r <= part_s[CHUNK];
            cnt_r   <= cnt_r - CW'(1);
            done_r  <= (cnt_r == CW'(1));
        end
    end

    assign result = sum_r[W-1:0];
    assign carry  = sum_r[W];
    assign done   = done_r;

endmodule

// File: rtl/montgomery_mult.sv
// Bit-serial Montgomery multiplier: result = A*B*2^-N mod M via a shared multi-cycle adder.
// Define MONT_FINAL_SUB_EN to enable the final conditional subtraction (result < M).
module montgomery_mult
    import montgomery_mult_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] result,
    output logic         done
);
    localparam int W  = add_width(N);
    localparam int IB = $clog2(N);
    localparam int IW = IB + 1;

    mont_state_e   state_r;
    mont_state_e   next_state_s;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [N-1:0]  m_r;
    logic [N:0]    c_r;
    logic [IW-1:0] i_r;
    logic [IW-1:0] i_inc_s;
    logic          done_r;
    logic [N-1:0]  result_r;

    logic          add_start_s;
    logic          add_sub_s;
    logic [W-1:0]  add_a_s;
    logic [W-1:0]  add_b_s;
    logic [W-1:0]  add_result_s;
    logic          add_carry_s;
    logic          add_done_s;
    logic          add_unused_s;

    assign i_inc_s      = i_r + IW'(1);
    assign add_unused_s = ^add_result_s[W-1:N+1];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    if (start) next_state_s = LOAD; else next_state_s = IDLE;
            LOAD:    next_state_s = next_step(a_r[i_r[IB-1:0]], c_r[0]);
            ADD_B:   next_state_s = WAIT_B;
            WAIT_B: begin
                if (add_done_s) begin
                    if (add_result_s[0]) next_state_s = ADD_M; else next_state_s = SHIFT;
                end else begin
                    next_state_s = WAIT_B;
                end
            end
            ADD_M:   next_state_s = WAIT_M;
            WAIT_M:  if (add_done_s) next_state_s = SHIFT; else next_state_s = WAIT_M;
            SHIFT: begin
                if (i_r == IW'(N - 1)) begin
`ifdef MONT_FINAL_SUB_EN
                    // A zero accumulator needs no reduction, so no adder work is issued.
                    if (|c_r[N:1]) next_state_s = SUB; else next_state_s = DONE;
`else
                    next_state_s = DONE;
`endif
                end else begin
                    next_state_s = next_step(a_r[i_inc_s[IB-1:0]], c_r[1]);
                end
            end
            SUB:     next_state_s = WAIT_S;
            WAIT_S:  if (add_done_s) next_state_s = DONE; else next_state_s = WAIT_S;
            DONE:    if (start) next_state_s = LOAD; else next_state_s = DONE;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM outputs: adder request and operands, held stable through each wait state.
    always_comb begin
        add_start_s = 1'b0;
        add_sub_s   = 1'b0;
        add_a_s     = {1'b0, c_r};
        add_b_s     = {2'b00, b_r};
        case (state_r)
            ADD_B:   add_start_s = ~rst;
            ADD_M: begin
                add_start_s = ~rst;
                add_b_s     = {2'b00, m_r};
            end
            WAIT_M:  add_b_s = {2'b00, m_r};
            SUB: begin
                add_start_s = ~rst;
                add_sub_s   = 1'b1;
                add_b_s     = {2'b00, m_r};
            end
            WAIT_S: begin
                add_sub_s = 1'b1;
                add_b_s   = {2'b00, m_r};
            end
            default: add_start_s = 1'b0;
        endcase
    end

    // Datapath: operand latch, accumulator, bit index and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= {N{1'b0}};
            b_r      <= {N{1'b0}};
            m_r      <= {N{1'b0}};
            c_r      <= {(N+1){1'b0}};
            i_r      <= {IW{1'b0}};
            done_r   <= 1'b0;
            result_r <= {N{1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        a_r    <= in_a;
                        b_r    <= in_b;
                        m_r    <= in_m;
                        c_r    <= {(N+1){1'b0}};
                        i_r    <= {IW{1'b0}};
                        done_r <= 1'b0;
                    end
                end
                WAIT_B, WAIT_M: if (add_done_s) c_r <= add_result_s[N:0];
                SHIFT: begin
                    c_r <= {1'b0, c_r[N:1]};
                    i_r <= i_inc_s;
                end
                WAIT_S: if (add_done_s && add_carry_s) c_r <= add_result_s[N:0];
                default: c_r <= c_r;
            endcase
            if ((next_state_s == DONE) && (state_r != DONE)) begin
                done_r <= 1'b1;
                if (state_r == WAIT_S) begin
                    result_r <= add_carry_s ? add_result_s[N-1:0] : c_r[N-1:0];
                end else begin
                    result_r <= c_r[N:1];
                end
            end
        end
    end

    montgomery_mult_adder #(
        .W     (W),
        .CHUNK (ADD_CHUNK)
    ) u_adder (
        .clk      (clk),
        .resetn   (~rst),
        .start    (add_start_s),
        .subtract (add_sub_s),
        .shift    (1'b0),
        .in_a     (add_a_s),
        .in_b     (add_b_s),
        .result   (add_result_s),
        .carry    (add_carry_s),
        .done     (add_done_s)
    );

    assign result = result_r;
    assign done   = done_r;

endmodule

// File: doc/montgomery_mult.md
MONTGOMERY_MULT -- requirements
Module: montgomery_mult

Interface
REQ-001 SHALL have parameter N, default 512, giving the operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port start  input  1  single-cycle request; sampled only in IDLE.
REQ-005 SHALL have port in_a  input  N  multiplier operand A, with A < M.
REQ-006 SHALL have port in_b  input  N  multiplicand operand B, with B < M.
REQ-007 SHALL have port in_m  input  N  odd modulus M, with M < 2^(N-1).
REQ-008 SHALL have port result  output  N  A*B*2^-N mod M.
REQ-009 SHALL have port done  output  1  result valid, level signal.

Function
REQ-010 SHALL latch in_a, in_b and in_m on the start cycle; inputs are don't-care afterwards.
REQ-011 SHALL act as initiator to the multi-cycle adder and drive its start, subtract, in_a and in_b.
REQ-012 SHALL hold adder start high for exactly one cycle per operation, then hold operands stable until adder done.
REQ-013 SHALL capture adder result bits [N:0] into accumulator C (N+1 bits) on the first cycle adder done is high.
REQ-014 SHALL use FSM states IDLE, LOAD, ADD_B, WAIT_B, ADD_M, WAIT_M, SHIFT, SUB, WAIT_S, DONE.
REQ-015 IDLE->LOAD on start; LOAD clears C and loop index i=0.
REQ-016 LOAD->ADD_B if A[i]=1, else ->ADD_M if C[0]=1, else ->SHIFT; this decision SHALL be evaluated only in LOAD/SHIFT.
REQ-017 WAIT_B, on capture, SHALL go to ADD_M if the new C[0]=1, else to SHIFT.
REQ-018 WAIT_M, on capture, SHALL go to SHIFT.
REQ-019 SHIFT SHALL set C <= C>>1 internally in one cycle (adder shift tied 0) and increment i.
REQ-020 SHALL go SHIFT->SUB when i reaches N, otherwise apply the REQ-016 decision for the new i.
REQ-021 SUB SHALL issue C-M with subtract=1; in WAIT_S, on adder done, it SHALL keep the difference if carry=1 (C>=M), else keep C.
REQ-022 DONE SHALL drive done=1 and result=C[N-1:0], holding both until the next accepted start.
REQ-023 A start in DONE SHALL clear done the next cycle and enter LOAD.
REQ-024 A start in any state other than IDLE or DONE SHALL be ignored, with no effect on the operation in progress.
REQ-025 A=0 SHALL give result 0 with no adder operation issued.
REQ-026 Worst-case latency SHALL be at most N*(2*(T_add+2)+1)+T_add+4 cycles from start to done, where T_add is adder start-to-done latency.

Reset
REQ-027 While rst=1, the FSM SHALL go to IDLE, with done=0, result=0, C=0, i=0, and adder start=0.
REQ-028 rst mid-operation SHALL abort it, and the block SHALL drive the adder reset so its count returns to 0 the same cycle.
REQ-029 The first start after rst deasserts SHALL complete correctly.

Configuration
REQ-030 With macro MONT_FINAL_SUB_EN defined, SUB/WAIT_S SHALL be present and result SHALL be < M.
REQ-031 Without MONT_FINAL_SUB_EN, SHIFT SHALL go directly to DONE when i=N, and result SHALL be < 2M (unreduced).

Structure
REQ-032 A shared package SHALL hold N_DEFAULT, the FSM state enum, and the adder-width constant (N+2).
REQ-033 The design SHALL have exactly one sub-module, the existing multi-cycle adder, instantiated once with resetn=~rst.
REQ-034 The block SHALL contain no wide multiplier and no combinational N-bit adder of its own.

Verification
REQ-035 N=512, M=3, A=1, B=1 SHALL give result=1 with done=1, held until the next start.
REQ-036 M=3, A=2, B=2 SHALL give result=1; M=2^511-1, with A and B random and below M, SHALL match the golden model A*B*2^-512 mod M over 200 vectors.
REQ-037 A=0, B=5, M=7 SHALL give result=0 and zero adder start pulses.
REQ-038 Asserting rst at cycle 100 of an operation SHALL give done=0 and result=0 on the next cycle; a new start (A=B=1, M=3) SHALL give 1.
REQ-039 A start pulsed at cycle 50 of a busy operation SHALL be ignored, leaving the original result correct and giving exactly one done rise.
REQ-040 Without MONT_FINAL_SUB_EN, M=3, A=2, B=2 SHALL give result in {1,4} that is congruent to 1 mod 3.
